// File: rtl/wave_dispatcher_if.sv
// Block-dispatcher and SIMD-side signals of one wave dispatcher, bundled for port connection.
// slave = the dispatcher itself; master = the block dispatcher / SIMD side that drives it.
interface wave_dispatcher_if #(
  parameter int unsigned NUM_SIMDS = 2
);
  logic                        enable;
  logic [31:0]                 num_threads;
  logic [31:0]                 block_dim;
  logic                        block_start;
  logic signed [31:0]          block_id_in;
  logic                        busy;
  logic                        block_done;
  logic signed [31:0]          block_id;
  logic [31:0]                 num_waves_in_block;
  logic [NUM_SIMDS*32-1:0]     wave_id;
  logic [NUM_SIMDS-1:0]        simd_ready;
  logic [NUM_SIMDS-1:0]        simd_start;
  logic [NUM_SIMDS-1:0]        simd_working;
  logic [NUM_SIMDS-1:0]        simd_done;

  modport master (
    output enable, num_threads, block_dim, block_start, block_id_in, simd_done,
    input  busy, block_done, block_id, num_waves_in_block, wave_id,
           simd_ready, simd_start, simd_working
  );

  modport slave (
    input  enable, num_threads, block_dim, block_start, block_id_in, simd_done,
    output busy, block_done, block_id, num_waves_in_block, wave_id,
           simd_ready, simd_start, simd_working
  );
endinterface

// File: rtl/wave_dispatcher.sv
// Per-CU wave dispatcher: sizes one block into waves, hands them to free SIMDs, reports block_done.
// Define WAVE_DISPATCH_ROUND_ROBIN_EN for round-robin SIMD selection (default: lowest index wins).
module wave_dispatcher #(
  parameter int unsigned NUM_SIMDS = 2,
  parameter int unsigned WAVE_SIZE = 32
) (
  input logic              clk,
  input logic              rst,
  wave_dispatcher_if.slave bus
);
  localparam int unsigned WAVE_SHIFT = $clog2(WAVE_SIZE);
  localparam int unsigned IDX_W      = (NUM_SIMDS > 1) ? $clog2(NUM_SIMDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_DISPATCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SIMD_READY,
    SIMD_START,
    SIMD_WORKING
  } simd_state_t;

  state_t                  state_q;
  simd_state_t             simd_st_q [NUM_SIMDS];
  logic signed [31:0]      block_id_q;
  logic [31:0]             num_waves_q;
  logic [31:0]             dispatched_q;
  logic [31:0]             retired_q;
  logic [NUM_SIMDS*32-1:0] wave_id_q;
  logic [NUM_SIMDS-1:0]    ready_q;
  logic [NUM_SIMDS-1:0]    start_q;
  logic [NUM_SIMDS-1:0]    working_q;
  logic                    busy_q;
  logic                    block_done_q;
`ifdef WAVE_DISPATCH_ROUND_ROBIN_EN
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        cand_d;
`endif

  logic [31:0]          prod_d;
  logic [31:0]          rem_d;
  logic [31:0]          thr_d;
  logic [32:0]          thr_round_d;
  logic [31:0]          num_waves_d;
  logic                 grant_vld_d;
  logic [IDX_W-1:0]     grant_idx_d;
  logic                 dispatch_d;
  logic [NUM_SIMDS-1:0] retire_hit_d;
  logic [31:0]          retire_cnt_d;

  // Threads left for this block; a non-positive remainder means the block is past the kernel end.
  always_comb begin
    prod_d = $unsigned(block_id_q) * bus.block_dim;
    rem_d  = bus.num_threads - prod_d;
    if ($signed(rem_d) <= 32'sd0) begin
      thr_d = '0;
    end else if (bus.block_dim < rem_d) begin
      thr_d = bus.block_dim;
    end else begin
      thr_d = rem_d;
    end
    thr_round_d = {1'b0, thr_d} + 33'(WAVE_SIZE - 1);
    num_waves_d = 32'(thr_round_d >> WAVE_SHIFT);
  end

  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
`ifdef WAVE_DISPATCH_ROUND_ROBIN_EN
    cand_d = '0;
    for (int unsigned i = 0; i < NUM_SIMDS; i++) begin
      cand_d = IDX_W'((32'(rr_ptr_q) + 32'd1 + i) % NUM_SIMDS);
      if (!grant_vld_d && ready_q[cand_d]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_d;
      end
    end
`else
    for (int unsigned i = 0; i < NUM_SIMDS; i++) begin
      if (!grant_vld_d && ready_q[i]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = IDX_W'(i);
      end
    end
`endif
    dispatch_d = grant_vld_d && (state_q == ST_DISPATCH) && (dispatched_q < num_waves_q);
  end

  always_comb begin
    retire_hit_d = working_q & bus.simd_done;
    retire_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_SIMDS; i++) begin
      retire_cnt_d = retire_cnt_d + 32'(retire_hit_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      block_id_q   <= '0;
      num_waves_q  <= '0;
      dispatched_q <= '0;
      retired_q    <= '0;
      wave_id_q    <= '0;
      ready_q      <= '1;
      start_q      <= '0;
      working_q    <= '0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_SIMDS; k++) begin
        simd_st_q[k] <= SIMD_READY;
      end
`ifdef WAVE_DISPATCH_ROUND_ROBIN_EN
      rr_ptr_q     <= IDX_W'(NUM_SIMDS - 1);
`endif
    end else if (bus.enable) begin
      block_done_q <= (state_q == ST_DONE);
      retired_q    <= retired_q + retire_cnt_d;
      if (dispatch_d) begin
        dispatched_q <= dispatched_q + 32'd1;
      end

      // CALC clears the counters; nothing can dispatch or retire in that cycle.
      case (state_q)
        ST_IDLE: begin
          if (bus.block_start) begin
            block_id_q <= bus.block_id_in;
            busy_q     <= 1'b1;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          num_waves_q  <= num_waves_d;
          dispatched_q <= '0;
          retired_q    <= '0;
          state_q      <= (num_waves_d == '0) ? ST_DONE : ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (dispatched_q == num_waves_q) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (retired_q == num_waves_q) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      for (int unsigned k = 0; k < NUM_SIMDS; k++) begin
        case (simd_st_q[k])
          SIMD_READY: begin
            if (dispatch_d && (grant_idx_d == IDX_W'(k))) begin
              simd_st_q[k]         <= SIMD_START;
              wave_id_q[k*32 +: 32] <= dispatched_q;
              ready_q[k]           <= 1'b0;
              start_q[k]           <= 1'b1;
            end
          end
          SIMD_START: begin
            simd_st_q[k] <= SIMD_WORKING;
            start_q[k]   <= 1'b0;
            working_q[k] <= 1'b1;
          end
          SIMD_WORKING: begin
            if (bus.simd_done[k]) begin
              simd_st_q[k] <= SIMD_READY;
              working_q[k] <= 1'b0;
              ready_q[k]   <= 1'b1;
            end
          end
          default: begin
            simd_st_q[k] <= SIMD_READY;
            ready_q[k]   <= 1'b1;
            start_q[k]   <= 1'b0;
            working_q[k] <= 1'b0;
          end
        endcase
      end

`ifdef WAVE_DISPATCH_ROUND_ROBIN_EN
      if (dispatch_d) begin
        rr_ptr_q <= grant_idx_d;
      end
`endif
    end
  end

  assign bus.busy               = busy_q;
  assign bus.block_done         = block_done_q;
  assign bus.block_id           = block_id_q;
  assign bus.num_waves_in_block = num_waves_q;
  assign bus.wave_id            = wave_id_q;
  assign bus.simd_ready         = ready_q;
  assign bus.simd_start         = start_q;
  assign bus.simd_working       = working_q;
endmodule

// File: tb/tb_wave_dispatcher.sv
// Self-checking bench for wave_dispatcher: directed scenarios plus randomized blocks
// checked against a wave-count / wave-order reference model.
module tb_wave_dispatcher;
  localparam int unsigned NS = 2;
  localparam int unsigned WS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wave_dispatcher_if #(.NUM_SIMDS(NS)) bus ();

  wave_dispatcher #(.NUM_SIMDS(NS), .WAVE_SIZE(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [31:0] nt, input logic [31:0] bd, input int bid);
    bus.num_threads = nt;
    bus.block_dim   = bd;
    bus.block_id_in = bid;
    bus.block_start = 1'b1;
    tick();
    bus.block_start = 1'b0;
  endtask

  // Retire every working SIMD each cycle until block_done appears or the budget runs out.
  task automatic finish_block(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      bus.simd_done = bus.simd_working;
      tick();
      if (bus.block_done) seen = 1'b1;
    end
    bus.simd_done = '0;
  endtask

  function automatic longint ref_waves(input logic [31:0] nt, input logic [31:0] bd, input int bid);
    logic [31:0] owned;
    longint rem;
    longint thr;
    owned = 32'(longint'(bid) * longint'(bd));
    rem   = longint'($signed(nt - owned));
    if (rem <= 0) thr = 0;
    else if (longint'(bd) < rem) thr = longint'(bd);
    else thr = rem;
    return (thr + longint'(WS) - 1) / longint'(WS);
  endfunction

  task automatic test_reset();
    bus.enable = 1'b1; bus.num_threads = '0; bus.block_dim = '0;
    bus.block_start = 1'b0; bus.block_id_in = '0; bus.simd_done = '0;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.block_done !== 1'b0) $display("FAIL reset_block_done: got %0b want 0", bus.block_done); else n_pass++;
    n_checks++; if (bus.simd_ready !== 2'b11) $display("FAIL reset_ready: got %b want 11", bus.simd_ready); else n_pass++;
    n_checks++; if (bus.simd_start !== 2'b00 || bus.simd_working !== 2'b00)
      $display("FAIL reset_start_working: got %b/%b want 00/00", bus.simd_start, bus.simd_working); else n_pass++;
    n_checks++; if (bus.wave_id !== '0 || bus.num_waves_in_block !== 32'd0 || bus.block_id !== 32'sd0)
      $display("FAIL reset_data: got wave_id %0h nw %0d id %0d want 0", bus.wave_id, bus.num_waves_in_block, bus.block_id); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit early; bit seen;
    start_block(64, 64, 0);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", bus.busy); else n_pass++;
    tick();
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(64, 64, 0)))
      $display("FAIL basic_num_waves: got %0d want %0d", bus.num_waves_in_block, ref_waves(64, 64, 0)); else n_pass++;
    tick();
    n_checks++; if (bus.simd_start !== 2'b01 || bus.wave_id[31:0] !== 32'd0)
      $display("FAIL basic_wave0: got start %b id %0d want 01 id 0", bus.simd_start, bus.wave_id[31:0]); else n_pass++;
    tick();
    n_checks++; if (bus.simd_start !== 2'b10 || bus.wave_id[63:32] !== 32'd1)
      $display("FAIL basic_wave1: got start %b id %0d want 10 id 1", bus.simd_start, bus.wave_id[63:32]); else n_pass++;
    early = 1'b0;
    repeat (4) begin tick(); if (bus.block_done) early = 1'b1; end
    n_checks++; if (early !== 1'b0) $display("FAIL basic_early_done: got %0b want 0", early); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL basic_done: got %0b want 1", seen); else n_pass++;
    tick();
    n_checks++; if (bus.block_done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_after_done: got done %0b busy %0b want 0 0", bus.block_done, bus.busy); else n_pass++;
  endtask

  task automatic test_tail();
    bit early; bit seen;
    start_block(100, 64, 1);
    tick();
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(100, 64, 1)))
      $display("FAIL tail_num_waves: got %0d want %0d", bus.num_waves_in_block, ref_waves(100, 64, 1)); else n_pass++;
    repeat (3) tick();
    bus.simd_done = 2'b01;
    tick();
    bus.simd_done = 2'b00;
    early = 1'b0;
    repeat (5) begin tick(); if (bus.block_done) early = 1'b1; end
    n_checks++; if (early !== 1'b0) $display("FAIL tail_early_done: got %0b want 0", early); else n_pass++;
    n_checks++; if (bus.simd_ready !== 2'b01 || bus.simd_working !== 2'b10)
      $display("FAIL tail_state: got ready %b working %b want 01 10", bus.simd_ready, bus.simd_working); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL tail_done: got %0b want 1", seen); else n_pass++;
  endtask

  task automatic test_oversub();
    bit stray; bit seen;
    start_block(128, 128, 0);
    tick();
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(128, 128, 0)))
      $display("FAIL oversub_num_waves: got %0d want %0d", bus.num_waves_in_block, ref_waves(128, 128, 0)); else n_pass++;
    repeat (2) tick();
    stray = 1'b0;
    repeat (4) begin tick(); if (bus.simd_start != 2'b00) stray = 1'b1; end
    n_checks++; if (stray !== 1'b0) $display("FAIL oversub_stall: got start during stall %0b want 0", stray); else n_pass++;
    bus.simd_done = 2'b10;
    tick();
    bus.simd_done = 2'b00;
    n_checks++; if (bus.simd_start !== 2'b00) $display("FAIL oversub_same_cycle: got %b want 00", bus.simd_start); else n_pass++;
    tick();
    n_checks++; if (bus.simd_start !== 2'b10 || bus.wave_id[63:32] !== 32'd2)
      $display("FAIL oversub_wave2: got start %b id %0d want 10 id 2", bus.simd_start, bus.wave_id[63:32]); else n_pass++;
    bus.simd_done = 2'b01;
    tick();
    bus.simd_done = 2'b00;
    tick();
    n_checks++; if (bus.simd_start !== 2'b01 || bus.wave_id[31:0] !== 32'd3)
      $display("FAIL oversub_wave3: got start %b id %0d want 01 id 3", bus.simd_start, bus.wave_id[31:0]); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL oversub_done: got %0b want 1", seen); else n_pass++;
  endtask

  task automatic test_empty();
    start_block(100, 64, 2);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL empty_busy: got %0b want 1", bus.busy); else n_pass++;
    bus.block_id_in = 7;
    bus.block_start = 1'b1;
    tick();
    bus.block_start = 1'b0;
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(100, 64, 2)) || bus.block_done !== 1'b0)
      $display("FAIL empty_calc: got nw %0d done %0b want %0d 0", bus.num_waves_in_block, bus.block_done, ref_waves(100, 64, 2)); else n_pass++;
    tick();
    n_checks++; if (bus.block_done !== 1'b1 || bus.simd_start !== 2'b00)
      $display("FAIL empty_done: got done %0b start %b want 1 00", bus.block_done, bus.simd_start); else n_pass++;
    tick();
    n_checks++; if (bus.block_done !== 1'b0 || bus.busy !== 1'b0 || bus.block_id !== 32'sd2)
      $display("FAIL empty_after: got done %0b busy %0b id %0d want 0 0 2", bus.block_done, bus.busy, bus.block_id); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_block(1000, 64, 3);
    repeat (4) tick();
    bus.simd_done = 2'b10;
    tick();
    bus.simd_done = 2'b00;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.block_done !== 1'b0 || bus.simd_working !== 2'b00 || bus.simd_ready !== 2'b11)
      $display("FAIL midreset_ctrl: got busy %0b done %0b work %b ready %b want 0 0 00 11",
               bus.busy, bus.block_done, bus.simd_working, bus.simd_ready); else n_pass++;
    n_checks++; if (bus.block_id !== 32'sd0 || bus.num_waves_in_block !== 32'd0 || bus.wave_id !== '0)
      $display("FAIL midreset_data: got id %0d nw %0d wave_id %0h want 0", bus.block_id, bus.num_waves_in_block, bus.wave_id); else n_pass++;
    rst = 1'b1;
    tick();
    start_block(32, 32, 0);
    tick();
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(32, 32, 0)))
      $display("FAIL midreset_nw: got %0d want %0d", bus.num_waves_in_block, ref_waves(32, 32, 0)); else n_pass++;
    tick();
    n_checks++; if (bus.simd_start !== 2'b01 || bus.wave_id[31:0] !== 32'd0)
      $display("FAIL midreset_wave0: got start %b id %0d want 01 0", bus.simd_start, bus.wave_id[31:0]); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL midreset_done: got %0b want 1", seen); else n_pass++;
  endtask

  task automatic test_pointer();
    bit seen;
    int last_grant;
    int pick;
    logic [1:0] exp_start;
    start_block(96, 96, 0);
    tick();
    n_checks++; if (bus.num_waves_in_block !== 32'(ref_waves(96, 96, 0)))
      $display("FAIL pointer_nw: got %0d want %0d", bus.num_waves_in_block, ref_waves(96, 96, 0)); else n_pass++;
    repeat (4) tick();
    bus.simd_done = 2'b11;
    tick();
    bus.simd_done = 2'b00;
    tick();
    // wave1 went to SIMD1; both SIMDs are idle when wave2 is chosen
    last_grant = 1;
    pick = -1;
`ifdef WAVE_DISPATCH_ROUND_ROBIN_EN
    for (int i = 1; i <= int'(NS) && pick < 0; i++) pick = (last_grant + i) % int'(NS);
`else
    pick = 0;
`endif
    exp_start = 2'b00;
    exp_start[pick] = 1'b1;
    n_checks++; if (bus.simd_start !== exp_start || bus.wave_id[pick*32 +: 32] !== 32'd2)
      $display("FAIL pointer_wave2: got start %b id %0d want %b id 2", bus.simd_start, bus.wave_id[pick*32 +: 32], exp_start); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL pointer_done: got %0b want 1", seen); else n_pass++;
  endtask

  task automatic test_enable();
    bit seen;
    bus.enable = 1'b0;
    start_block(64, 64, 5);
    repeat (3) tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.block_id !== 32'sd0)
      $display("FAIL enable_ignore: got busy %0b id %0d want 0 0", bus.busy, bus.block_id); else n_pass++;
    bus.enable = 1'b1;
    start_block(64, 64, 0);
    repeat (2) tick();
    bus.enable = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.simd_start !== 2'b01 || bus.simd_working !== 2'b00 || bus.simd_ready !== 2'b10)
      $display("FAIL enable_freeze: got start %b work %b ready %b want 01 00 10",
               bus.simd_start, bus.simd_working, bus.simd_ready); else n_pass++;
    bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.simd_start !== 2'b10 || bus.simd_working !== 2'b01)
      $display("FAIL enable_resume: got start %b work %b want 10 01", bus.simd_start, bus.simd_working); else n_pass++;
    finish_block(50, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL enable_done: got %0b want 1", seen); else n_pass++;
  endtask

  task automatic test_random();
    for (int b = 0; b < 20; b++) begin
      logic [31:0] nt;
      logic [31:0] bd;
      int bid;
      longint exp_nw;
      bit mbusy [NS];
      int cd [NS];
      int next_wave;
      int order_err;
      int overlap_err;
      bit done_seen;
      nt  = 32'($urandom_range(0, 300));
      bd  = 32'($urandom_range(0, 160));
      bid = int'($urandom_range(0, 6));
      exp_nw = ref_waves(nt, bd, bid);
      for (int k = 0; k < int'(NS); k++) begin mbusy[k] = 1'b0; cd[k] = 0; end
      next_wave = 0; order_err = 0; overlap_err = 0; done_seen = 1'b0;
      start_block(nt, bd, bid);
      for (int c = 0; c < 400 && !done_seen; c++) begin
        bus.simd_done = '0;
        for (int k = 0; k < int'(NS); k++) begin
          if (mbusy[k] && bus.simd_working[k]) begin
            if (cd[k] == 0) begin bus.simd_done[k] = 1'b1; mbusy[k] = 1'b0; end
            else cd[k]--;
          end
        end
        tick();
        for (int k = 0; k < int'(NS); k++) begin
          if (bus.simd_start[k]) begin
            if (mbusy[k]) overlap_err++;
            if (bus.wave_id[k*32 +: 32] !== 32'(next_wave)) order_err++;
            next_wave++;
            mbusy[k] = 1'b1;
            cd[k] = int'($urandom_range(0, 4));
          end
        end
        if (bus.block_done) done_seen = 1'b1;
      end
      bus.simd_done = '0;
      n_checks++; if (done_seen !== 1'b1)
        $display("FAIL rand_done[%0d]: got %0b want 1 (nt %0d bd %0d bid %0d)", b, done_seen, nt, bd, bid); else n_pass++;
      n_checks++; if (bus.num_waves_in_block !== 32'(exp_nw))
        $display("FAIL rand_nw[%0d]: got %0d want %0d", b, bus.num_waves_in_block, exp_nw); else n_pass++;
      n_checks++; if (longint'(next_wave) != exp_nw)
        $display("FAIL rand_starts[%0d]: got %0d want %0d", b, next_wave, exp_nw); else n_pass++;
      n_checks++; if (order_err != 0 || overlap_err != 0)
        $display("FAIL rand_order[%0d]: got order_err %0d overlap_err %0d want 0 0", b, order_err, overlap_err); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_oversub();
    test_empty();
    test_reset_mid();
    test_pointer();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
